sp_ram_arbiter: RTL and testbench
=================================

Name: sp_ram_arbiter

Overview:
- Two-port round-robin arbiter that shares one single-port byte-enable RAM (sp_ram_m8) between two requesters, e.g. core instruction fetch and data LSU, using the PULP req/gnt/rvalid protocol.
- Grants at most one access per cycle and drives the RAM port.
- Returns registered read data, qualified by per-port rvalid, one cycle after grant.
- Keeps a saturating conflict counter for performance debug.

Parameters:
- ADDR_WIDTH, 8, word-address width of the RAM and of both requester ports.
- DATA_WIDTH, 32, data width; multiple of 8.
- CNT_WIDTH, 16, width of the conflict counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- pN_req_i  in  1  request from port N (N=0,1)
- pN_gnt_o  out  1  grant to port N; combinational, same cycle as req
- pN_addr_i  in  ADDR_WIDTH  word address
- pN_we_i  in  1  1=write, 0=read
- pN_be_i  in  DATA_WIDTH/8  byte enables
- pN_wdata_i  in  DATA_WIDTH  write data
- pN_rvalid_o  out  1  response valid, one cycle after pN_gnt_o
- pN_rdata_o  out  DATA_WIDTH  read data; meaningful only when pN_rvalid_o=1
- ram_en_o  out  1  RAM enable
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  DATA_WIDTH/8  RAM byte enables
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_rdata_i  in  DATA_WIDTH  RAM read data; registered in RAM, valid the cycle after access
- cnt_clr_i  in  1  synchronous clear of conflict counter
- conflict_cnt_o  out  CNT_WIDTH  cycles in which both ports requested

Behaviour:
- Reset values: pN_rvalid_o=0, conflict_cnt_o=0, last_q=1 (so port 0 wins the first conflict).
- Grant logic (combinational):
  - Only p0_req_i=1: p0_gnt_o=1.
  - Only p1_req_i=1: p1_gnt_o=1.
  - Both requesting: grant the port != last_q.
  - p0_gnt_o and p1_gnt_o are never both 1.
- Round-robin state: on every cycle with a grant, last_q <= granted port index. Idle cycles leave last_q unchanged.
- RAM drive:
  - ram_en_o = p0_gnt_o | p1_gnt_o.
  - ram_addr_o, ram_we_o, ram_be_o and ram_wdata_o mux from the granted port.
  - With no grant, ram_en_o=0, ram_we_o=0, ram_be_o=0; address and data don't-care, held at port 0 values.
- Response path:
  - rvalid_q[N] <= pN_gnt_o; pN_rvalid_o = rvalid_q[N].
  - ram_rdata_i is broadcast to both pN_rdata_o.
  - Writes also return rvalid; rdata is don't-care on write responses.
- Latency: read data at gnt cycle +1. Sustained throughput is 1 access/cycle total, and one port alone gets 1 access/cycle. A port may re-request in the cycle its rvalid is high.
- Protocol rules, checked by bench assertions:
  - A requester holds req, addr, we, be and wdata stable from req rise until gnt.
  - req may not drop before gnt.
- be=0 write: still granted and still returns rvalid; RAM contents unchanged.
- Conflict counter:
  - Increments by 1 in each cycle with p0_req_i & p1_req_i.
  - Saturates at all-ones.
  - cnt_clr_i=1 clears to 0 and takes priority over an increment in the same cycle.
- Reset mid-operation: rvalid clears immediately and asynchronously; the in-flight response is discarded. last_q returns to 1.
- No internal buffering; a denied request simply waits. Worst-case wait under contention is 1 cycle.

Test Plan:
- Port 0 only: write addr 0x10 = 0xDEADBEEF, be=4'hF, then read 0x10 -> gnt same cycle; p0_rvalid_o one cycle later with rdata 0xDEADBEEF; p1_rvalid_o stays 0.
- Both ports request reads (0x01, 0x02) continuously from reset for 6 cycles:
  - Grants alternate p0, p1, p0, p1, p0, p1.
  - Each rvalid follows its gnt by 1 cycle with the correct data.
  - conflict_cnt_o=6.
- Byte-enable write: 0x11223344 to 0x20, then 0xAABBCCDD with be=4'b0101, then read -> 0x11BB33DD. A be=0 write leaves the word unchanged and still returns rvalid.
- Back-to-back: port 1 issues 4 consecutive reads with port 0 idle -> 4 grants in 4 cycles; rvalid high for 4 consecutive cycles.
- Counter saturation with CNT_WIDTH=4: 20 conflict cycles -> count stops at 15. Assert cnt_clr_i during a conflict cycle -> count reads 0 next cycle.
- Assert rst_n low in the cycle after a p0 grant -> p0_rvalid_o drops to 0 immediately. After release, a simultaneous request is granted to port 0 first.

Source files
------------

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter sharing one single-port byte-enable RAM between two
// req/gnt/rvalid requesters, with a saturating conflict counter for debug.
module sp_ram_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      p0_req_i,
  output logic                      p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]     p0_addr_i,
  input  logic                      p0_we_i,
  input  logic [DATA_WIDTH/8-1:0]   p0_be_i,
  input  logic [DATA_WIDTH-1:0]     p0_wdata_i,
  output logic                      p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]     p0_rdata_o,

  input  logic                      p1_req_i,
  output logic                      p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]     p1_addr_i,
  input  logic                      p1_we_i,
  input  logic [DATA_WIDTH/8-1:0]   p1_be_i,
  input  logic [DATA_WIDTH-1:0]     p1_wdata_i,
  output logic                      p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]     p1_rdata_o,

  output logic                      ram_en_o,
  output logic [ADDR_WIDTH-1:0]     ram_addr_o,
  output logic                      ram_we_o,
  output logic [DATA_WIDTH/8-1:0]   ram_be_o,
  output logic [DATA_WIDTH-1:0]     ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]     ram_rdata_i,

  input  logic                      cnt_clr_i,
  output logic [CNT_WIDTH-1:0]      conflict_cnt_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 last_q, last_d;
  logic [1:0]           rvalid_q, rvalid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 conflict;

  // last_q names the port served most recently; on contention the other wins.
  always_comb begin
    conflict = p0_req_i & p1_req_i;
    p0_gnt_o = p0_req_i & (~p1_req_i | last_q);
    p1_gnt_o = p1_req_i & (~p0_req_i | ~last_q);
  end

  always_comb begin
    ram_en_o    = p0_gnt_o | p1_gnt_o;
    ram_addr_o  = p1_gnt_o ? p1_addr_i  : p0_addr_i;
    ram_wdata_o = p1_gnt_o ? p1_wdata_i : p0_wdata_i;
    ram_we_o    = (p0_gnt_o & p0_we_i) | (p1_gnt_o & p1_we_i);
    ram_be_o    = '0;
    if (p0_gnt_o) begin
      ram_be_o = p0_be_i;
    end else if (p1_gnt_o) begin
      ram_be_o = p1_be_i;
    end
  end

  always_comb begin
    last_d = last_q;
    if (p0_gnt_o) begin
      last_d = 1'b0;
    end else if (p1_gnt_o) begin
      last_d = 1'b1;
    end

    rvalid_d = {p1_gnt_o, p0_gnt_o};

    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (conflict && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= 1'b1;
      rvalid_q <= 2'b00;
      cnt_q    <= '0;
    end else begin
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      cnt_q    <= cnt_d;
    end
  end

  // The RAM registers its own read data, so responses are a pure broadcast.
  assign p0_rvalid_o    = rvalid_q[0];
  assign p1_rvalid_o    = rvalid_q[1];
  assign p0_rdata_o     = ram_rdata_i;
  assign p1_rdata_o     = ram_rdata_i;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Directed bench for sp_ram_arbiter with a behavioural byte-enable RAM model
// and protocol checks on the requester side.
module tb_sp_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          p0_req, p0_gnt, p0_we, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [BW-1:0] p0_be;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_gnt, p1_we, p1_rvalid;
  logic [AW-1:0] p1_addr;
  logic [BW-1:0] p1_be;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          cnt_clr;
  logic [CW-1:0] conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req), .p0_gnt_o(p0_gnt), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
    .p0_be_i(p0_be), .p0_wdata_i(p0_wdata), .p0_rvalid_o(p0_rvalid), .p0_rdata_o(p0_rdata),
    .p1_req_i(p1_req), .p1_gnt_o(p1_gnt), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
    .p1_be_i(p1_be), .p1_wdata_i(p1_wdata), .p1_rvalid_o(p1_rvalid), .p1_rdata_o(p1_rdata),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .cnt_clr_i(cnt_clr), .conflict_cnt_o(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: read-before-write, registered read data.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < BW; b++) begin
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
      ram_rdata <= mem[ram_addr];
    end
  end

  // Requesters must hold a denied request unchanged until it is granted.
  logic pend0, pend1;
  logic [AW+1+BW+DW-1:0] snap0, snap1;
  always @(posedge clk) begin
    if (!rst_n) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      if (pend0) assert (p0_req && ({p0_addr, p0_we, p0_be, p0_wdata} == snap0))
        else $error("protocol violation on port 0");
      if (pend1) assert (p1_req && ({p1_addr, p1_we, p1_be, p1_wdata} == snap1))
        else $error("protocol violation on port 1");
      pend0 <= p0_req & ~p0_gnt;
      pend1 <= p1_req & ~p1_gnt;
      snap0 <= {p0_addr, p0_we, p0_be, p0_wdata};
      snap1 <= {p1_addr, p1_we, p1_be, p1_wdata};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic port, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [BW-1:0] be,
                       input logic [DW-1:0] wd);
    if (port == 1'b0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_be = be; p0_wdata = wd;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_be = be; p1_wdata = wd;
    end
  endtask

  // One uncontended access; called at posedge+1, returns at posedge+1.
  task automatic single(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd,
                        input logic chk_data, input logic [DW-1:0] exp_rd, input string tag);
    drive(port, 1'b1, we, addr, be, wd);
    drive(~port, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check({tag, "_gnt"},   {p1_gnt, p0_gnt}, port ? 2'b10 : 2'b01);
    check({tag, "_addr"},  ram_addr, addr);
    check({tag, "_we_be"}, {ram_en, ram_we, ram_be}, {1'b1, we, be});
    tick;
    drive(port, 1'b0, 1'b0, '0, '0, '0);
    check({tag, "_rvalid"}, {p1_rvalid, p0_rvalid}, port ? 2'b10 : 2'b01);
    if (chk_data) check({tag, "_rdata"}, port ? p1_rdata : p0_rdata, exp_rd);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick;
  endtask

  logic g1;

  initial begin
    rst_n = 1'b0;
    cnt_clr = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    #12;
    check("rst_rvalid", {p1_rvalid, p0_rvalid}, 2'b00);
    check("rst_cnt", conflict_cnt, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check("idle_ram", {ram_en, ram_we, ram_be}, 6'b0);

    // port 0 alone, write then read back in the rvalid cycle
    single(1'b0, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF, 1'b0, '0, "p0_wr");
    single(1'b0, 1'b0, 8'h10, 4'hF, '0, 1'b1, 32'hDEADBEEF, "p0_rd");

    // byte enables, including an all-zero write
    single(1'b0, 1'b1, 8'h20, 4'hF, 32'h11223344, 1'b0, '0, "be_wr1");
    single(1'b0, 1'b1, 8'h20, 4'b0101, 32'hAABBCCDD, 1'b0, '0, "be_wr2");
    single(1'b0, 1'b0, 8'h20, 4'hF, '0, 1'b1, 32'h11BB33DD, "be_rd1");
    single(1'b1, 1'b1, 8'h20, 4'h0, 32'hFFFFFFFF, 1'b0, '0, "be_wr0");
    single(1'b0, 1'b0, 8'h20, 4'hF, '0, 1'b1, 32'h11BB33DD, "be_rd2");

    // seed data for the read tests
    single(1'b0, 1'b1, 8'h01, 4'hF, 32'hA1A1A1A1, 1'b0, '0, "seed1");
    single(1'b0, 1'b1, 8'h02, 4'hF, 32'hB2B2B2B2, 1'b0, '0, "seed2");
    for (int i = 0; i < 4; i++)
      single(1'b1, 1'b1, 8'h30 + 8'(i), 4'hF, 32'h30000000 + 32'(i), 1'b0, '0, "seed3x");

    // contention from reset: p0 first, then strict alternation
    do_reset;
    drive(1'b0, 1'b1, 1'b0, 8'h01, 4'hF, '0);
    drive(1'b1, 1'b1, 1'b0, 8'h02, 4'hF, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rr_gnt", {p1_gnt, p0_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) begin
        check("rr_rvalid", {p1_rvalid, p0_rvalid}, ((i - 1) % 2 == 0) ? 2'b01 : 2'b10);
        check("rr_rdata", ((i - 1) % 2 == 0) ? p0_rdata : p1_rdata,
              ((i - 1) % 2 == 0) ? 32'hA1A1A1A1 : 32'hB2B2B2B2);
      end
      tick;
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("rr_tail_gnt", {p1_gnt, p0_gnt}, 2'b01);
    check("rr_tail_rv1", {p1_rvalid, p0_rvalid}, 2'b10);
    check("rr_tail_rd1", p1_rdata, 32'hB2B2B2B2);
    check("rr_cnt6", conflict_cnt, 4'd6);
    tick;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    check("rr_tail_rv0", {p1_rvalid, p0_rvalid}, 2'b01);
    check("rr_tail_rd0", p0_rdata, 32'hA1A1A1A1);

    // port 1 back-to-back reads, port 0 idle
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'h30 + 8'(i), 4'hF, '0);
      @(negedge clk);
      check("b2b_gnt", {p1_gnt, p0_gnt}, 2'b10);
      if (i > 0) begin
        check("b2b_rvalid", p1_rvalid, 1'b1);
        check("b2b_rdata", p1_rdata, 32'h30000000 + 32'(i - 1));
      end
      tick;
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    check("b2b_last_rv", p1_rvalid, 1'b1);
    check("b2b_last_rd", p1_rdata, 32'h30000003);
    tick;
    check("b2b_rv_off", {p1_rvalid, p0_rvalid}, 2'b00);

    // counter clear, count, saturation, clear during conflict
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    check("cnt_clr_idle", conflict_cnt, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 8'h01, 4'hF, '0);
    drive(1'b1, 1'b1, 1'b0, 8'h02, 4'hF, '0);
    for (int i = 0; i < 20; i++) begin
      tick;
      if (i == 9) check("cnt_10", conflict_cnt, 4'd10);
    end
    check("cnt_sat", conflict_cnt, 4'd15);
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    check("cnt_clr_conf", conflict_cnt, 4'd0);
    @(negedge clk);
    g1 = p1_gnt;
    tick;
    check("cnt_after_clr", conflict_cnt, 4'd1);
    drive(g1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("sat_drain_gnt", {p1_gnt, p0_gnt}, g1 ? 2'b01 : 2'b10);
    tick;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);

    // reset with a response in flight; last grant was p0
    drive(1'b0, 1'b1, 1'b0, 8'h01, 4'hF, '0);
    tick;
    check("mid_rv_pre", p0_rvalid, 1'b1);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b0;
    #1;
    check("mid_rv_async", {p1_rvalid, p0_rvalid}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    drive(1'b0, 1'b1, 1'b0, 8'h01, 4'hF, '0);
    drive(1'b1, 1'b1, 1'b0, 8'h02, 4'hF, '0);
    @(negedge clk);
    check("post_rst_gnt", {p1_gnt, p0_gnt}, 2'b01);
    tick;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    check("post_rst_gnt2", {p1_gnt, p0_gnt}, 2'b10);
    tick;
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
